// File: rtl/sbox_layer_scheduler_pkg.sv
// Shared types and constants for the serial masked S-box layer scheduler.
package sbox_sched_pkg;

  localparam int NIBBLES = 16;
  localparam int NIB_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } state_e;

  // One slot of the latency tracker: marks a real issue and which nibble it carries.
  typedef struct packed {
    logic             valid;
    logic [NIB_W-1:0] tag;
  } lat_ent_t;

  // Pick nibble idx (bits [4*idx+3 : 4*idx]) out of a single 64-bit share.
  function automatic logic [NIB_W-1:0] nib_sel(input logic [63:0] v, input logic [3:0] idx);
    return v[{idx, 2'b00} +: NIB_W];
  endfunction

endpackage

// File: rtl/sbox_layer_scheduler_lat_tracker.sv
// LAT-deep shift register of {valid, tag} that mirrors the S-box pipeline,
// so each result coming out of the core can be routed back to its nibble.
module sbox_lat_tracker
  import sbox_sched_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [NIB_W-1:0] i_tag,
  output logic             o_valid,
  output logic [NIB_W-1:0] o_tag
);

  lat_ent_t r_pipe [LAT];

  // Shift one entry per clock; a bubble travels as valid=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this small array is cleared on reset on purpose: a stale valid bit
      // surviving a mid-layer reset would retire garbage into the next layer.
      for (int i = 0; i < LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= '{valid: i_valid, tag: i_tag};
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[LAT-1].valid;
  assign o_tag   = r_pipe[LAT-1].tag;

endmodule

// File: rtl/sbox_layer_scheduler.sv
// Serialises a two-share 64-bit state through one shared masked 4-bit S-box.
// Nibbles are only presented together with fresh randomness; results are
// written back by tag as they emerge LAT cycles later. Share 0 and share 1
// travel on fully separate datapaths.
module sbox_layer_scheduler
  import sbox_sched_pkg::*;
#(
  parameter int LAT     = 1,
  parameter int FRESH_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [63:0]        in_s0,
  input  logic [63:0]        in_s1,
  output logic               busy,
  output logic               done,
  output logic [63:0]        out_s0,
  output logic [63:0]        out_s1,
  output logic [3:0]         sb_x_s0,
  output logic [3:0]         sb_x_s1,
  output logic [FRESH_W-1:0] sb_fresh,
  input  logic [3:0]         sb_y_s0,
  input  logic [3:0]         sb_y_s1,
  output logic               rnd_req,
  input  logic               rnd_valid,
  input  logic [FRESH_W-1:0] rnd_data
);

  state_e           r_state;
  logic [CNT_W-1:0] r_iss;
  logic [CNT_W-1:0] r_ret;
  logic [63:0]      r_s0;
  logic [63:0]      r_s1;
  logic [63:0]      r_out_s0;
  logic [63:0]      r_out_s1;

  logic             w_issue;
  logic             w_retire;
  logic             w_ret_valid;
  logic [NIB_W-1:0] w_ret_tag;

  // An issue needs both the FEED state and a randomness transfer this cycle.
  assign w_issue  = (r_state == FEED) && rnd_valid;
  assign w_retire = w_ret_valid && ((r_state == FEED) || (r_state == DRAIN));

  // Drive the S-box only in issue cycles; bubbles present all-zero inputs.
  always_comb begin
    // NOTE: every output gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    sb_x_s0  = '0;
    sb_x_s1  = '0;
    sb_fresh = '0;
    if (w_issue) begin
      sb_x_s0  = nib_sel(r_s0, r_iss[3:0]);
      sb_x_s1  = nib_sel(r_s1, r_iss[3:0]);
      sb_fresh = rnd_data;
    end
  end

  sbox_lat_tracker #(
    .LAT (LAT)
  ) u_lat_tracker (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_issue),
    .i_tag   (r_iss[3:0]),
    .o_valid (w_ret_valid),
    .o_tag   (w_ret_tag)
  );

  // Layer control: latch shares, count issues and retires, sequence the states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_iss   <= '0;
      r_ret   <= '0;
      r_s0    <= '0;
      r_s1    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // branch below reads the pre-edge values of r_iss and r_ret.
      if (w_retire) begin
        r_ret <= r_ret + CNT_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_s0    <= in_s0;
            r_s1    <= in_s1;
            r_iss   <= '0;
            r_ret   <= '0;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (w_issue) begin
            r_iss <= r_iss + CNT_W'(1);
            if (r_iss == CNT_W'(NIBBLES - 1)) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_retire && (r_ret == CNT_W'(NIBBLES - 1))) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write each retired result nibble into its slot; untouched nibbles hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_s0 <= '0;
      r_out_s1 <= '0;
    end else if (w_retire) begin
      r_out_s0[{w_ret_tag, 2'b00} +: NIB_W] <= sb_y_s0;
      r_out_s1[{w_ret_tag, 2'b00} +: NIB_W] <= sb_y_s1;
    end
  end

  // Status outputs are plain decodes of the state register.
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == DONE);
  assign rnd_req = (r_state == FEED);
  assign out_s0  = r_out_s0;
  assign out_s1  = r_out_s1;

endmodule

// File: tb/tb_sbox_layer_scheduler.sv
// Directed bench: two scheduler instances (LAT=1 and LAT=3) driven by one
// stimulus, each connected to a behavioural masked S-box of matching latency.
module tb_sbox_layer_scheduler;

  localparam logic [63:0] VEC_A0 = 64'h5A5A5A5A5A5A5A5A;
  localparam logic [63:0] VEC_A1 = 64'h5A5A5A5A5A5A5A5A ^ 64'h0123456789ABCDEF;
  localparam logic [63:0] EXP_A  = 64'hC6901A2B385D4E7F;
  localparam logic [63:0] VEC_B0 = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] VEC_B1 = 64'h0F1E2D3C4B5A6978 ^ 64'hFEDCBA9876543210;
  localparam logic [63:0] EXP_B  = 64'hF7E4D583B2A1096C;
  localparam logic [63:0] RND_K  = 64'h9E3779B97F4A7C15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] in_s0, in_s1;
  logic        rnd_valid;
  logic [63:0] rnd_data;

  logic        busy1, done1, req1, busy3, done3, req3;
  logic [63:0] out1_s0, out1_s1, out3_s0, out3_s1, fresh1, fresh3;
  logic [3:0]  x1_s0, x1_s1, y1_s0, y1_s1, x3_s0, x3_s1, y3_s0, y3_s1;
  logic [3:0]  p3_s0 [3];
  logic [3:0]  p3_s1 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sbox_layer_scheduler #(.LAT(1), .FRESH_W(64)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_s0(in_s0), .in_s1(in_s1),
    .busy(busy1), .done(done1), .out_s0(out1_s0), .out_s1(out1_s1),
    .sb_x_s0(x1_s0), .sb_x_s1(x1_s1), .sb_fresh(fresh1),
    .sb_y_s0(y1_s0), .sb_y_s1(y1_s1),
    .rnd_req(req1), .rnd_valid(rnd_valid), .rnd_data(rnd_data)
  );

  sbox_layer_scheduler #(.LAT(3), .FRESH_W(64)) dut3 (
    .clk(clk), .rst(rst), .start(start), .in_s0(in_s0), .in_s1(in_s1),
    .busy(busy3), .done(done3), .out_s0(out3_s0), .out_s1(out3_s1),
    .sb_x_s0(x3_s0), .sb_x_s1(x3_s1), .sb_fresh(fresh3),
    .sb_y_s0(y3_s0), .sb_y_s1(y3_s1),
    .rnd_req(req3), .rnd_valid(rnd_valid), .rnd_data(rnd_data)
  );

  // Skinny-64 S-box table, nibble i holds S(i).
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hF7E4D583B2A1096C;
    return tbl[{x, 2'b00} +: 4];
  endfunction

  // Masked S-box models: y_s0 = S(x) ^ r, y_s1 = r, with r = fresh[3:0].
  always @(posedge clk) begin
    y1_s0 <= sbox(x1_s0 ^ x1_s1) ^ fresh1[3:0];
    y1_s1 <= fresh1[3:0];
    p3_s0[0] <= sbox(x3_s0 ^ x3_s1) ^ fresh3[3:0];
    p3_s1[0] <= fresh3[3:0];
    p3_s0[1] <= p3_s0[0];
    p3_s1[1] <= p3_s1[0];
    p3_s0[2] <= p3_s0[1];
    p3_s1[2] <= p3_s1[1];
  end
  assign y3_s0 = p3_s0[2];
  assign y3_s1 = p3_s1[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out1_s0"}, out1_s0, 64'd0);
    check({tag, "_out1_s1"}, out1_s1, 64'd0);
    check({tag, "_ctl1"}, {53'd0, busy1, done1, req1, x1_s0, x1_s1}, 64'd0);
    check({tag, "_fresh1"}, fresh1, 64'd0);
    check({tag, "_out3"}, out3_s0 | out3_s1 | fresh3, 64'd0);
  endtask

  // Runs one layer on both DUTs, cycle k = k-th cycle after the start edge.
  task automatic run_layer(input string name, input logic [63:0] s0, input logic [63:0] s1,
                           input logic [63:0] exp_x, input logic [63:0] prev_x,
                           input logic [63:0] stall_mask, input logic [63:0] start_mask,
                           input int exp_done1, input int exp_done3, input int rst_cycle,
                           input bit chk_mid);
    int cycle, d1, d3, iss, glitch;
    logic [3:0]  c4;
    logic [63:0] t0, t1, xr3;
    @(negedge clk);
    check({name, "_idle"}, {62'd0, busy1, done1}, 64'd0);
    start = 1'b1;
    in_s0 = s0;
    in_s1 = s1;
    cycle = 0; d1 = 0; d3 = 0; iss = 0; glitch = 0;
    while (cycle < 40) begin
      @(negedge clk);
      cycle++;
      c4        = cycle[3:0];
      start     = start_mask[cycle];
      in_s0     = start_mask[cycle] ? ~s0 : s0;
      rnd_valid = !stall_mask[cycle];
      rnd_data  = RND_K ^ {16{c4}};
      if (cycle == rst_cycle) begin
        rst = 1'b0;
        #1;
        check_reset_outputs({name, "_async_rst"});
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        return;
      end
      #1;
      if (cycle == 1) check({name, "_hold_prev"}, out1_s0 ^ out1_s1, prev_x);
      if (chk_mid && cycle == 10)
        check({name, "_mid_layer"}, out1_s0 ^ out1_s1, {prev_x[63:32], exp_x[31:0]});
      if (iss < 16) begin
        if (stall_mask[cycle]) begin
          check({name, "_bubble"}, {51'd0, req1, x1_s0, x1_s1} | fresh1, 64'h1_00);
        end else begin
          t0 = s0 >> (4 * iss);
          t1 = s1 >> (4 * iss);
          check({name, "_issue_x"}, {56'd0, x1_s0, x1_s1}, {56'd0, t0[3:0], t1[3:0]});
          check({name, "_issue_fresh"}, fresh1, rnd_data);
          iss++;
        end
      end
      if (exp_done3 != 0 && cycle >= 5 && cycle <= 20) begin
        xr3 = out3_s0 ^ out3_s1;
        t0  = xr3 >> (4 * (cycle - 5));
        t1  = exp_x >> (4 * (cycle - 5));
        check({name, "_lat3_retired"}, {60'd0, t0[3:0]}, {60'd0, t1[3:0]});
        if (cycle <= 19) begin
          t0 = xr3 >> (4 * (cycle - 4));
          t1 = exp_x >> (4 * (cycle - 4));
          if (t1[3:0] != 4'h0) check({name, "_lat3_not_early"}, {60'd0, t0[3:0]}, 64'd0);
        end
      end
      if (d1 == 0 && busy1 !== 1'b1) glitch++;
      if (done1 === 1'b1 && d1 == 0) d1 = cycle;
      if (done3 === 1'b1 && d3 == 0) d3 = cycle;
      if (d1 != 0 && (exp_done3 == 0 || d3 != 0)) break;
    end
    start = 1'b0;
    check({name, "_done_cycle"}, 64'(d1), 64'(exp_done1));
    check({name, "_result"}, out1_s0 ^ out1_s1, exp_x);
    check({name, "_busy_glitch"}, 64'(glitch), 64'd0);
    if (exp_done3 != 0) begin
      check({name, "_lat3_done_cycle"}, 64'(d3), 64'(exp_done3));
      check({name, "_lat3_result"}, out3_s0 ^ out3_s1, exp_x);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    in_s0     = '0;
    in_s1     = '0;
    rnd_valid = 1'b0;
    rnd_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Masked correctness on both latencies, no stalls.
    run_layer("masked", VEC_A0, VEC_A1, EXP_A, 64'd0, 64'd0, 64'd0, 18, 20, 0, 1'b1);
    // Randomness bubbles in cycles 3, 7 and 8.
    run_layer("stall", VEC_A0, VEC_A1, EXP_A, EXP_A, (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 8),
              64'd0, 21, 0, 0, 1'b0);
    // start pulses in cycles 5 and 12 with a different in_s0 must be ignored.
    run_layer("start_busy", VEC_B0, VEC_B1, EXP_B, EXP_A, 64'd0, (64'd1 << 5) | (64'd1 << 12),
              18, 0, 0, 1'b1);
    // Back-to-back: start in the cycle after done.
    run_layer("b2b", VEC_A0, VEC_A1, EXP_A, EXP_B, 64'd0, 64'd0, 18, 0, 0, 1'b1);
    // Asynchronous reset in cycle 9, then a clean layer.
    run_layer("rst_mid", VEC_B0, VEC_B1, EXP_B, EXP_A, 64'd0, 64'd0, 0, 0, 9, 1'b0);
    run_layer("after_rst", VEC_A0, VEC_A1, EXP_A, 64'd0, 64'd0, 64'd0, 18, 0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbox_layer_scheduler.md
Name: sbox_layer_scheduler

Overview:
- Serialises a two-share 64-bit state, 16 nibbles, through one shared first-order masked 4-bit S-box instance. The S-box is the low-latency, clock-gated, two-share core.
- Sources 64 fresh random bits per S-box evaluation from the PRNG over a request/valid handshake.
- Tracks the S-box pipeline latency and writes each masked result nibble back into the output state.
- Sits between the round-function datapath and the S-box core in the serial masked Skinny-64 implementation.

Parameters:
- LAT, 1, S-box input-to-output latency in clock cycles (1..4).
- FRESH_W, 64, fresh-randomness bits per S-box evaluation.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a layer; sampled only in IDLE
- in_s0  in  64  state share 0
- in_s1  in  64  state share 1
- busy  out  1  high from the cycle after start until DONE is left
- done  out  1  one-cycle pulse; out_s0/out_s1 valid from this cycle until the next start
- out_s0  out  64  result share 0
- out_s1  out  64  result share 1
- sb_x_s0  out  4  S-box input share 0
- sb_x_s1  out  4  S-box input share 1
- sb_fresh  out  FRESH_W  S-box randomness
- sb_y_s0  in  4  S-box output share 0
- sb_y_s1  in  4  S-box output share 1
- rnd_req  out  1  randomness request
- rnd_valid  in  1  randomness available; a transfer occurs when rnd_req && rnd_valid
- rnd_data  in  FRESH_W  randomness word

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst=0), from any state including mid-layer:
  - state=IDLE, all counters and valid/tag pipe cleared, latched shares cleared.
  - out_s0=out_s1=0; busy=done=rnd_req=0.
  - sb_x_s0=sb_x_s1=0, sb_fresh=0.
- FSM states IDLE, FEED, DRAIN, DONE.
  - IDLE: on start=1, latch in_s0/in_s1, clear issue count (iss) and retire count (ret), go to FEED. start is ignored in every other state.
  - FEED: rnd_req=1.
    - If rnd_valid=1: drive nibble iss, i.e. bits [4*iss+3 : 4*iss] of each latched share, onto sb_x_s0/sb_x_s1, drive rnd_data onto sb_fresh, push valid=1 with tag=iss into the LAT-deep pipe, and increment iss.
    - If rnd_valid=0: insert a bubble. sb_x_s0/sb_x_s1/sb_fresh are driven to 0 and valid=0 is pushed. No share data is presented without fresh randomness.
    - When iss reaches 15 and issues, go to DRAIN.
  - DRAIN: rnd_req=0; sb inputs are 0. Go to DONE in the cycle ret reaches 16.
  - DONE: done=1 for one cycle, then IDLE.
- Retire (FEED and DRAIN):
  - When the pipe output valid=1, write sb_y_s0/sb_y_s1 into nibble tag of out_s0/out_s1 and increment ret.
  - Retires may coincide with issues.
- Shares are never combined: no XOR, mux or register shares a bit of s0 with a bit of s1.
- out_s0/out_s1 hold their value through IDLE. Nibbles not yet retired hold their previous-layer value and are not exposed until done.
- Latency, no stalls:
  - start sampled at edge 0; nibbles issued in cycles 1..16.
  - done asserted in cycle 17+LAT (cycle 18 for LAT=1).
  - Each rnd_valid=0 cycle in FEED adds exactly one cycle.
- Counters: iss and ret are 5 bits. They do not wrap within a layer and are cleared on start.

Decomposition:
- Package sbox_sched_pkg holds:
  - NIBBLES=16
  - state enum {IDLE, FEED, DRAIN, DONE}
  - count width 5
  - nibble-select helper function
- One sub-module, sbox_lat_tracker: LAT-deep shift register of {valid, 4-bit tag}; async active-low clear.

Test Plan:
- Masked correctness: rnd_valid=1 constant; in_s0=0x5A5A5A5A5A5A5A5A, in_s1=in_s0^0x0123456789ABCDEF, S-box model LAT=1 -> out_s0^out_s1=0xC6901A2B385D4E7F, done in cycle 18 after start.
- Randomness stalls: rnd_valid low for cycles 3, 7 and 8 of FEED -> sb_x_s0/sb_x_s1/sb_fresh=0 in those cycles; same result as the first scenario; done 3 cycles later (cycle 21).
- LAT=3 variant: same vector -> same result; done in cycle 20; each tag retired exactly 3 cycles after its issue.
- Reset mid-operation: rst=0 in cycle 9 -> all outputs 0 immediately (asynchronous). After release a new start produces a correct full layer with no stale retires.
- start while busy: pulse start in cycles 5 and 12 with different in_s0 -> ignored; result matches the original input; busy stays high with no glitch.
- Back-to-back layers: start in the cycle after done -> second layer correct; out_s0/out_s1 hold the first result until overwritten nibble by nibble.
